// File: rtl/digital_tube_scan_ctrl.sv
// digital_tube_scan_ctrl: bus-mapped scan controller for tube0/tube1 (4 digits, multiplexed) and tube2 (1 digit).
// Optional leading-zero suppression on CTRL[10] is built only when TUBE_LZ_SUPPRESS_EN is defined.
module digital_tube_scan_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  digital_tube0,
  output logic [3:0]  digital_tube_sel0,
  output logic [7:0]  digital_tube1,
  output logic [3:0]  digital_tube_sel1,
  output logic [7:0]  digital_tube2,
  output logic        digital_tube_sel2
);
  localparam int DW = $clog2(SCAN_DIV);

  logic [31:0]   data0_q;
  logic [3:0]    data1_q;
  logic [9:0]    ctrl_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    tube0_q, tube1_q, tube2_q;
  logic [3:0]    sel0_q, sel1_q;
  logic          sel2_q;
  logic          wrap, lz_en, lz0, lz1, blank0, blank1, blank2;
  logic [3:0]    nib0, nib1;
  logic [8:0]    mask;

  function automatic logic [7:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 8'hc0;
      4'h1: seg7 = 8'hf9;
      4'h2: seg7 = 8'ha4;
      4'h3: seg7 = 8'hb0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hf8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'ha: seg7 = 8'h88;
      4'hb: seg7 = 8'h83;
      4'hc: seg7 = 8'hc6;
      4'hd: seg7 = 8'ha1;
      4'he: seg7 = 8'h86;
      default: seg7 = 8'h8e;
    endcase
  endfunction

  always_comb begin
    wrap  = div_q == DW'(SCAN_DIV - 1);
    div_d = wrap ? '0 : div_q + DW'(1);
    idx_d = idx_q + 2'(wrap);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data0_q <= '0;
      data1_q <= '0;
      ctrl_q  <= 10'h001;
      div_q   <= '0;
      idx_q   <= '0;
    end else begin
      if (we && addr == 2'd0) data0_q <= wdata;
      if (we && addr == 2'd1) data1_q <= wdata[3:0];
      if (we && addr == 2'd2) ctrl_q <= wdata[9:0];
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

`ifdef TUBE_LZ_SUPPRESS_EN
  logic lz_q;
  always_ff @(posedge clk) begin
    if (reset) lz_q <= 1'b0;
    else if (we && addr == 2'd2) lz_q <= wdata[10];
  end
  // a digit is a leading zero when it and every higher digit of its group is zero
  assign lz_en = lz_q;
  assign lz0 = lz_q && idx_q != 2'd0 && (data0_q[15:0] >> {idx_q, 2'b00}) == 16'h0;
  assign lz1 = lz_q && idx_q != 2'd0 && (data0_q[31:16] >> {idx_q, 2'b00}) == 16'h0;
`else
  assign lz_en = 1'b0;
  assign lz0 = 1'b0;
  assign lz1 = 1'b0;
`endif

  always_comb begin
    mask   = ctrl_q[9:1];
    nib0   = data0_q[{idx_q, 2'b00} +: 4];
    nib1   = data0_q[{1'b1, idx_q, 2'b00} +: 4];
    blank0 = mask[{2'b00, idx_q}] | lz0;
    blank1 = mask[{2'b01, idx_q}] | lz1;
    blank2 = mask[8];
  end

  always_ff @(posedge clk) begin
    if (reset || !ctrl_q[0]) begin
      tube0_q <= 8'hff;
      tube1_q <= 8'hff;
      tube2_q <= 8'hff;
      sel0_q  <= '0;
      sel1_q  <= '0;
      sel2_q  <= 1'b0;
    end else begin
      tube0_q <= blank0 ? 8'hff : seg7(nib0);
      tube1_q <= blank1 ? 8'hff : seg7(nib1);
      tube2_q <= blank2 ? 8'hff : seg7(data1_q);
      sel0_q  <= 4'b0001 << idx_q;
      sel1_q  <= 4'b0001 << idx_q;
      sel2_q  <= 1'b1;
    end
  end

  always_comb
    rdata = addr == 2'd0 ? data0_q :
            addr == 2'd1 ? {28'b0, data1_q} :
            addr == 2'd2 ? {21'b0, lz_en, ctrl_q} : {30'b0, idx_q};

  assign digital_tube0     = tube0_q;
  assign digital_tube1     = tube1_q;
  assign digital_tube2     = tube2_q;
  assign digital_tube_sel0 = sel0_q;
  assign digital_tube_sel1 = sel1_q;
  assign digital_tube_sel2 = sel2_q;
endmodule

// File: tb/tb_digital_tube_scan_ctrl.sv
// tb_digital_tube_scan_ctrl: directed plus random bus traffic against a cycle-level reference model.
module tb_digital_tube_scan_ctrl;
`ifdef TUBE_LZ_SUPPRESS_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  localparam int DIV = 4;

  logic        clk, reset, we;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic [7:0]  t0, t1, t2;
  logic [3:0]  s0, s1;
  logic        s2;
  int          n_checks, n_fail;

  logic [31:0] m_data0;
  logic [3:0]  m_data1;
  logic [10:0] m_ctrl;
  int          m_n;

  logic [7:0] lut [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

  digital_tube_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata),
    .digital_tube0(t0), .digital_tube_sel0(s0),
    .digital_tube1(t1), .digital_tube_sel1(s1),
    .digital_tube2(t2), .digital_tube_sel2(s2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_idx();
    return (m_n / DIV) % 4;
  endfunction

  function automatic logic [23:0] exp_segs();
    logic [7:0] g [3];
    int idx, dig, hi;
    logic blank;
    idx = m_idx();
    if (!m_ctrl[0]) return 24'hffffff;
    for (int t = 0; t < 2; t++) begin
      dig = idx + 4 * t;
      hi = 0;
      for (int k = 0; k < 4; k++)
        if (m_data0[4 * (k + 4 * t) +: 4] != 4'h0) hi = k;
      blank = m_ctrl[1 + dig] || (LZ && m_ctrl[10] && idx > hi);
      g[t] = blank ? 8'hff : lut[m_data0[4 * dig +: 4]];
    end
    g[2] = m_ctrl[9] ? 8'hff : lut[m_data1];
    return {g[0], g[1], g[2]};
  endfunction

  function automatic logic [8:0] exp_sels();
    logic [3:0] one;
    one = 4'(1 << m_idx());
    return m_ctrl[0] ? {one, one, 1'b1} : 9'h0;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [1:0] a);
    case (a)
      2'd0: return m_data0;
      2'd1: return {28'b0, m_data1};
      2'd2: return {21'b0, m_ctrl};
      default: return 32'(m_idx());
    endcase
  endfunction

  task automatic step(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
    logic [23:0] es;
    logic [8:0]  ess;
    reset = r; we = w; addr = a; wdata = d;
    es  = r ? 24'hffffff : exp_segs();
    ess = r ? 9'h0 : exp_sels();
    @(posedge clk);
    #1;
    if (r) begin
      m_data0 = '0; m_data1 = '0; m_ctrl = 11'h001; m_n = 0;
    end else begin
      if (w && a == 2'd0) m_data0 = d;
      if (w && a == 2'd1) m_data1 = d[3:0];
      if (w && a == 2'd2) m_ctrl = d[10:0] & (LZ ? 11'h7ff : 11'h3ff);
      m_n++;
    end
    check("segs", {8'h0, t0, t1, t2}, {8'h0, es});
    check("sels", {23'h0, s0, s1, s2}, {23'h0, ess});
    check("rdata", rdata, exp_rdata(a));
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_data0 = '0; m_data1 = '0; m_ctrl = 11'h001; m_n = 0;
    step(1, 0, 2'd2, 0);
    step(1, 0, 2'd2, 0);
    check("rst_ctrl", rdata, 32'h1);
    check("rst_segs", {t0, t1, t2}, 24'hffffff);
    step(0, 1, 2'd0, 32'h87654321);
    for (int i = 0; i < 20; i++) step(0, 0, 2'd3, 0);
    step(0, 1, 2'd1, 32'hfffffffe);
    check("data1_rd", rdata, 32'he);
    step(0, 0, 2'd1, 0);
    check("tube2", {24'h0, t2}, 32'h86);
    step(0, 1, 2'd2, 32'h0);
    step(0, 0, 2'd3, 0);
    check("dis_segs", {t0, t1, t2}, 24'hffffff);
    for (int i = 0; i < 6; i++) step(0, 0, 2'd3, 0);
    step(0, 1, 2'd2, 32'h1);
    for (int i = 0; i < 6; i++) step(0, 0, 2'd3, 0);
    step(0, 1, 2'd2, 32'h7);
    for (int i = 0; i < 18; i++) step(0, 0, 2'd0, 0);
    step(0, 1, 2'd0, 32'h5);
    step(0, 1, 2'd2, 32'h401);
    for (int i = 0; i < 18; i++) step(0, 0, 2'd2, 0);
    step(0, 1, 2'd0, 32'h00300020);
    for (int i = 0; i < 18; i++) step(0, 0, 2'd0, 0);
    step(0, 0, 2'd0, 0);
    step(1, 0, 2'd3, 0);
    for (int i = 0; i < 1500; i++) begin
      bit r, w;
      logic [1:0] a;
      logic [31:0] d;
      r = $urandom_range(0, 199) == 0;
      w = $urandom_range(0, 5) == 0;
      a = 2'($urandom_range(0, 3));
      d = $urandom_range(0, 2) == 0 ? ($urandom & 32'h0f00f0f0) : $urandom;
      if (w && a == 2'd2) d[0] = $urandom_range(0, 4) != 0;
      step(r, w, a, d);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
